// File: rtl/regbank.sv
// regbank -- 32 x 32-bit register storage feeding the 32:1 register-read mux.
//
// Every register is exposed continuously on its own output bus (Qn drives
// mux input Din n). A single write port updates one register per cycle. A
// sequenced clear zeroes the bank one register per cycle while Busy is high.
//
// Ports:
//   Clk      in   1   system clock, rising-edge active
//   Rst_n    in   1   asynchronous active-low reset (clears bank, FSM, Busy)
//   WE       in   1   write enable (honoured only while idle)
//   Awr      in   5   write address 0..31
//   Din      in  32   write data
//   Clr      in   1   clear request (honoured only while idle, wins over WE)
//   Busy     out  1   high while the clear sequence runs
//   Q0..Q31  out 32   current contents of registers 0..31
//
// Build option:
//   R0_ZERO_EN  when defined, register 0 reads as constant zero and writes
//               to address 0 are discarded.
module regbank (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        WE,
  input  logic [4:0]  Awr,
  input  logic [31:0] Din,
  input  logic        Clr,
  output logic        Busy,
  output logic [31:0] Q0,  output logic [31:0] Q1,
  output logic [31:0] Q2,  output logic [31:0] Q3,
  output logic [31:0] Q4,  output logic [31:0] Q5,
  output logic [31:0] Q6,  output logic [31:0] Q7,
  output logic [31:0] Q8,  output logic [31:0] Q9,
  output logic [31:0] Q10, output logic [31:0] Q11,
  output logic [31:0] Q12, output logic [31:0] Q13,
  output logic [31:0] Q14, output logic [31:0] Q15,
  output logic [31:0] Q16, output logic [31:0] Q17,
  output logic [31:0] Q18, output logic [31:0] Q19,
  output logic [31:0] Q20, output logic [31:0] Q21,
  output logic [31:0] Q22, output logic [31:0] Q23,
  output logic [31:0] Q24, output logic [31:0] Q25,
  output logic [31:0] Q26, output logic [31:0] Q27,
  output logic [31:0] Q28, output logic [31:0] Q29,
  output logic [31:0] Q30, output logic [31:0] Q31
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic        busy_q,  busy_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] we_dec;

  // One-hot write decode of Awr.
  always_comb begin
    we_dec = '0;
    if (WE) we_dec[Awr] = 1'b1;
`ifdef R0_ZERO_EN
    we_dec[0] = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        // A clear request takes priority; a same-edge write is dropped.
        if (Clr) begin
          state_d = CLEAR;
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
        end else begin
          for (int i = 0; i < 32; i++) begin
            if (we_dec[i]) regs_d[i] = Din;
          end
        end
      end
      CLEAR: begin
        // WE and Clr are ignored here; counter wraps 31 -> 0 on exit.
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign Busy = busy_q;

`ifdef R0_ZERO_EN
  assign Q0  = 32'h0000_0000;
`else
  assign Q0  = regs_q[0];
`endif
  assign Q1  = regs_q[1];
  assign Q2  = regs_q[2];
  assign Q3  = regs_q[3];
  assign Q4  = regs_q[4];
  assign Q5  = regs_q[5];
  assign Q6  = regs_q[6];
  assign Q7  = regs_q[7];
  assign Q8  = regs_q[8];
  assign Q9  = regs_q[9];
  assign Q10 = regs_q[10];
  assign Q11 = regs_q[11];
  assign Q12 = regs_q[12];
  assign Q13 = regs_q[13];
  assign Q14 = regs_q[14];
  assign Q15 = regs_q[15];
  assign Q16 = regs_q[16];
  assign Q17 = regs_q[17];
  assign Q18 = regs_q[18];
  assign Q19 = regs_q[19];
  assign Q20 = regs_q[20];
  assign Q21 = regs_q[21];
  assign Q22 = regs_q[22];
  assign Q23 = regs_q[23];
  assign Q24 = regs_q[24];
  assign Q25 = regs_q[25];
  assign Q26 = regs_q[26];
  assign Q27 = regs_q[27];
  assign Q28 = regs_q[28];
  assign Q29 = regs_q[29];
  assign Q30 = regs_q[30];
  assign Q31 = regs_q[31];

endmodule

// File: tb/tb_regbank.sv
module tb_regbank;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        WE = 1'b0;
  logic [4:0]  Awr = 5'd0;
  logic [31:0] Din = 32'd0;
  logic        Clr = 1'b0;
  logic        Busy;
  logic [31:0] q [32];

  int checks = 0;
  int failures = 0;

  // Reference model: bank contents, busy flag and clear position.
  logic [31:0] mreg [32];
  logic        mbusy = 1'b0;
  int          mpos = 0;

  regbank dut (
    .Clk(Clk), .Rst_n(Rst_n), .WE(WE), .Awr(Awr), .Din(Din), .Clr(Clr),
    .Busy(Busy),
    .Q0(q[0]),   .Q1(q[1]),   .Q2(q[2]),   .Q3(q[3]),
    .Q4(q[4]),   .Q5(q[5]),   .Q6(q[6]),   .Q7(q[7]),
    .Q8(q[8]),   .Q9(q[9]),   .Q10(q[10]), .Q11(q[11]),
    .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15]),
    .Q16(q[16]), .Q17(q[17]), .Q18(q[18]), .Q19(q[19]),
    .Q20(q[20]), .Q21(q[21]), .Q22(q[22]), .Q23(q[23]),
    .Q24(q[24]), .Q25(q[25]), .Q26(q[26]), .Q27(q[27]),
    .Q28(q[28]), .Q29(q[29]), .Q30(q[30]), .Q31(q[31])
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a clear occupies 1 + 32 edges, zeroing register (edge - start - 1).
  always @(negedge Rst_n) begin
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mbusy = 1'b0;
    mpos  = 0;
  end

  always @(posedge Clk) begin
    if (Rst_n) begin
      if (mbusy) begin
        mreg[mpos] = 32'd0;
        mpos++;
        if (mpos == 32) mbusy = 1'b0;
      end else if (Clr) begin
        mbusy = 1'b1;
        mpos  = 0;
      end else if (WE) begin
`ifdef R0_ZERO_EN
        if (Awr != 5'd0) mreg[Awr] = Din;
`else
        mreg[Awr] = Din;
`endif
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge Clk) begin
    if (Rst_n) begin
      chk("busy_model", {31'd0, Busy}, {31'd0, mbusy});
      for (int i = 0; i < 32; i++) chk($sformatf("q%0d_model", i), q[i], mreg[i]);
    end
  end

  // One rising edge with the given inputs; returns 1 time unit after the edge.
  task automatic tick(input logic we, input logic [4:0] a, input logic [31:0] d, input logic clr);
    @(negedge Clk);
    WE = we; Awr = a; Din = d; Clr = clr;
    @(posedge Clk);
    #1;
    WE = 1'b0; Clr = 1'b0;
  endtask

  task automatic chk_all(input string nm, input logic [31:0] exp);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_q%0d", nm, i), q[i], exp);
  endtask

  task automatic fill(input logic [31:0] d);
    for (int i = 0; i < 32; i++) tick(1'b1, i[4:0], d, 1'b0);
  endtask

  logic [31:0] r0_exp;

  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    #12;
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk_all("reset", 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Single write, then every address.
    tick(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    chk("wr5", q[5], 32'hDEADBEEF);
    chk("wr5_other", q[6], 32'd0);
    for (int n = 0; n < 32; n++) begin
      tick(1'b1, n[4:0], 32'h1000_0000 + n, 1'b0);
`ifdef R0_ZERO_EN
      chk($sformatf("wr_all%0d", n), q[n], (n == 0) ? 32'd0 : 32'h1000_0000 + n);
`else
      chk($sformatf("wr_all%0d", n), q[n], 32'h1000_0000 + n);
`endif
    end
    chk("wr_all_keep1", q[1], 32'h1000_0001);

    // Asynchronous reset mid-cycle.
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, Busy}, 32'd0);
    chk_all("async_rst", 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Plain clear sequence.
    fill(32'hFFFFFFFF);
    tick(1'b0, 5'd0, 32'd0, 1'b1);                 // edge N
    chk("clr_busy_N", {31'd0, Busy}, 32'd1);
    chk("clr_q0_N", q[0], 32'hFFFFFFFF);
    for (int e = 1; e <= 4; e++) tick(1'b0, 5'd0, 32'd0, 1'b0);
    chk("clr_q3_N4", q[3], 32'd0);
    chk("clr_q4_N4", q[4], 32'hFFFFFFFF);
    for (int e = 5; e <= 31; e++) tick(1'b0, 5'd0, 32'd0, 1'b0);
    chk("clr_busy_N31", {31'd0, Busy}, 32'd1);
    chk("clr_q31_N31", q[31], 32'hFFFFFFFF);
    tick(1'b0, 5'd0, 32'd0, 1'b0);                 // edge N+32
    chk("clr_busy_N32", {31'd0, Busy}, 32'd0);
    chk_all("clr_done", 32'd0);

    // Collisions during a clear.
    tick(1'b1, 5'd7, 32'h0000_0077, 1'b0);
    tick(1'b1, 5'd7, 32'h12345678, 1'b1);          // edge N: write dropped
    chk("col_same_edge", q[7], 32'h0000_0077);
    for (int e = 1; e <= 31; e++) begin
      if (e == 10) tick(1'b0, 5'd0, 32'd0, 1'b1);
      else if (e == 20) tick(1'b1, 5'd7, 32'h12345678, 1'b0);
      else tick(1'b0, 5'd0, 32'd0, 1'b0);
    end
    chk("col_busy_N31", {31'd0, Busy}, 32'd1);
    tick(1'b0, 5'd0, 32'd0, 1'b0);                 // edge N+32
    chk("col_busy_N32", {31'd0, Busy}, 32'd0);
    chk("col_q7_end", q[7], 32'd0);
    tick(1'b1, 5'd9, 32'h0000_0099, 1'b0);         // edge N+33
    chk("col_wr_after", q[9], 32'h0000_0099);

    // Reset in the middle of a clear.
    fill(32'h5555_AAAA);
    tick(1'b0, 5'd0, 32'd0, 1'b1);
    for (int e = 1; e <= 14; e++) tick(1'b0, 5'd0, 32'd0, 1'b0);
    chk("mid_busy", {31'd0, Busy}, 32'd1);
    chk("mid_q20", q[20], 32'h5555_AAAA);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
    chk("mid_rst_q20", q[20], 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick(1'b1, 5'd2, 32'hA5A5A5A5, 1'b0);
    chk("mid_wr2", q[2], 32'hA5A5A5A5);

    // Register 0 behaviour depends on the build option.
`ifdef R0_ZERO_EN
    r0_exp = 32'h0000_0000;
`else
    r0_exp = 32'hCAFEF00D;
`endif
    tick(1'b1, 5'd0, 32'hCAFEF00D, 1'b0);
    chk("r0_write", q[0], r0_exp);
    tick(1'b0, 5'd0, 32'd0, 1'b0);

    @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
